res_st_issue: RTL and testbench
===============================

Name: res_st_issue

Overview:
- Reservation station and issue stage directly downstream of the front end (fetch → decode → map → rename).
- Accepts renamed micro-ops on the front end's reservation-station write port (wr_en/wr_addr/wr_data).
- Captures operands broadcast on the common data bus (CDB) and issues fully-ready entries one per cycle to an execution unit over a valid/ready handshake.
- Reports the next free slot and a full flag back to rename.

Parameters:
- RS_DEPTH, 8: number of entries. Power of two, ≥2. res_st_addr_t is $clog2(RS_DEPTH) bits wide.
- TAG_WIDTH, $clog2(PHY_RF_DEPTH): physical register tag width.
- DATA_WIDTH, 32: operand width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- wr_en  in  1  write a new entry this cycle.
- wr_addr  in  res_st_addr_t  target slot.
- wr_data  in  res_st_cell_t  entry payload.
  - Fields used: uop (opaque), rd_tag, rs1_tag, rs1_rdy, rs1_val, rs2_tag, rs2_rdy, rs2_val.
- free_addr  out  res_st_addr_t  lowest-index empty slot; 0 when full.
- full  out  1  no empty slot.
- count  out  $clog2(RS_DEPTH+1)  number of occupied slots (issue register excluded).
- cdb_valid  in  1  CDB broadcast valid.
- cdb_tag  in  TAG_WIDTH  producing tag.
- cdb_data  in  DATA_WIDTH  produced value.
- issue_valid  out  1  issue register holds an instruction.
- issue_ready  in  1  execution unit accepts.
- issue_cell  out  res_st_cell_t  issued entry; rs1_val and rs2_val are final.
- flush  in  1  synchronous squash of all state.
- wr_err  out  1  one-cycle pulse: write to an occupied slot was dropped.

Behaviour:
- Reset (rst low, asynchronous):
  - All entry valid bits cleared; issue register empty.
  - issue_valid=0, issue_cell=0, full=0, free_addr=0, count=0, wr_err=0.
- Storage: RS_DEPTH entries, each a valid bit plus res_st_cell_t.
- Write:
  - On an edge with wr_en=1 and slot wr_addr empty, the slot is loaded and marked valid.
  - If the slot is occupied, the write is dropped and wr_err pulses high for the next cycle.
- Write/CDB bypass: if cdb_valid=1 and cdb_tag equals an incoming operand tag whose rdy=0, that operand is stored with rdy=1 and val=cdb_data in the same edge.
- Wakeup: on every edge with cdb_valid=1, each valid entry's operand with rdy=0 and matching tag captures cdb_data and sets rdy=1. Both operands of one entry may match the same broadcast.
- Tag 0: operands with tag 0 are always written with rdy=1 by rename; the station performs no special handling.
- Select (combinational from registered state): lowest-index valid entry with rs1_rdy=1 and rs2_rdy=1.
- Issue register:
  - "Load" means issue register empty, or issue_valid=1 with issue_ready=1.
  - When load holds and a candidate exists, the candidate moves into the issue register and its slot is cleared on that edge.
  - When load holds and no candidate exists, issue_valid falls to 0.
  - issue_cell is stable while issue_valid=1 and issue_ready=0.
- Latency: entry written ready at edge N → issue_valid=1 after edge N+1. Entry woken by CDB at edge N → issue at edge N+1.
- Throughput: one issue per cycle with issue_ready held high.
- Free slot / occupancy:
  - free_addr and full are combinational from current valid bits.
  - A slot freed by issue on edge N is reported free after edge N.
  - count updates on the same edges.
- Simultaneous write + issue on different slots: both take effect; count is unchanged.
- Flush:
  - Flush has priority over write, wakeup and issue.
  - On an edge with flush=1, all valid bits and the issue register are cleared.
  - After that edge: count=0, issue_valid=0, full=0.
  - No wr_err is raised for a write dropped by flush.
- Reset mid-operation: asynchronous clear as above; entries and the in-flight issue are lost.

Test Plan:
- Reset, then write slot 0: rs1_rdy=1, rs1_val=5, rs2_rdy=1, rs2_val=10, issue_ready=1 → issue_valid=1 one cycle after the write with issue_cell values 5 and 10; count returns to 0; free_addr=0.
- Write slot 1 with rs1_tag=7 not ready, rs2 ready. Two cycles later broadcast cdb_tag=7, cdb_data=0x55 → rs1_val=0x55 and issue occurs one cycle after the broadcast. A broadcast of tag 6 causes no wakeup.
- Fill all 8 slots with unready operands → full=1, count=8, free_addr=0. A write to slot 3 → wr_err pulses for one cycle and contents are unchanged.
- Backpressure: hold issue_ready=0 with 3 ready entries → issue_cell stays on the lowest-index entry. Release issue_ready → entries issue in index order 0,1,2 on consecutive cycles.
- Bypass: write an entry with rs2_tag=9 not ready in the same cycle as CDB tag 9 with data 0x1234 → entry issues with rs2_val=0x1234 and no further broadcast needed.
- Flush with 4 occupied slots and issue_valid=1 → count=0 and issue_valid=0 after the edge. Assert rst low mid-stream → all outputs go to reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/res_st_issue.sv
// Reservation station with CDB wakeup and a single-entry issue register.
// Oldest-by-index select feeds the execution unit over valid/ready.
package res_st_pkg;
   localparam int RS_DEPTH     = 8;
   localparam int PHY_RF_DEPTH = 64;
   localparam int TAG_WIDTH    = $clog2(PHY_RF_DEPTH);
   localparam int DATA_WIDTH   = 32;
   localparam int UOP_WIDTH    = 16;
   localparam int RS_AW        = $clog2(RS_DEPTH);
   localparam int CNT_W        = $clog2(RS_DEPTH + 1);

   typedef logic [RS_AW-1:0]      res_st_addr_t;
   typedef logic [TAG_WIDTH-1:0]  tag_t;
   typedef logic [DATA_WIDTH-1:0] data_t;

   typedef struct packed {
      logic [UOP_WIDTH-1:0] uop;
      tag_t                 rd_tag;
      tag_t                 rs1_tag;
      logic                 rs1_rdy;
      data_t                rs1_val;
      tag_t                 rs2_tag;
      logic                 rs2_rdy;
      data_t                rs2_val;
   } res_st_cell_t;
endpackage

module res_st_issue
   import res_st_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               wr_en,
   input  res_st_addr_t       wr_addr,
   input  res_st_cell_t       wr_data,
   output res_st_addr_t       free_addr,
   output logic               full,
   output logic [CNT_W-1:0]   count,
   input  logic               cdb_valid,
   input  tag_t               cdb_tag,
   input  data_t              cdb_data,
   output logic               issue_valid,
   input  logic               issue_ready,
   output res_st_cell_t       issue_cell,
   input  logic               flush,
   output logic               wr_err
);

   logic [RS_DEPTH-1:0] valid_q;
   res_st_cell_t        cells_q [RS_DEPTH];
   logic                issue_valid_q;
   res_st_cell_t        issue_cell_q;
   logic                wr_err_q;

   logic                cand_found;
   res_st_addr_t        cand_idx;
   logic                load;
   logic [CNT_W-1:0]    cnt;

   function automatic res_st_cell_t wake(input res_st_cell_t c,
                                         input logic         v,
                                         input tag_t         t,
                                         input data_t        d);
      res_st_cell_t r;
      r = c;
      if (v && !c.rs1_rdy && (c.rs1_tag == t)) begin
         r.rs1_rdy = 1'b1;
         r.rs1_val = d;
      end
      if (v && !c.rs2_rdy && (c.rs2_tag == t)) begin
         r.rs2_rdy = 1'b1;
         r.rs2_val = d;
      end
      return r;
   endfunction

   // Downward scan so the lowest matching index wins.
   always_comb begin
      cand_found = 1'b0;
      cand_idx   = '0;
      free_addr  = '0;
      cnt        = '0;
      for (int i = RS_DEPTH - 1; i >= 0; i--) begin
         if (valid_q[i] && cells_q[i].rs1_rdy && cells_q[i].rs2_rdy) begin
            cand_found = 1'b1;
            cand_idx   = RS_AW'(i);
         end
         if (!valid_q[i]) begin
            free_addr = RS_AW'(i);
         end
         cnt = cnt + CNT_W'(valid_q[i]);
      end
   end

   assign full        = &valid_q;
   assign count       = cnt;
   assign load        = !issue_valid_q || issue_ready;
   assign issue_valid = issue_valid_q;
   assign issue_cell  = issue_cell_q;
   assign wr_err      = wr_err_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_q       <= '0;
         issue_valid_q <= 1'b0;
         issue_cell_q  <= '0;
         wr_err_q      <= 1'b0;
         for (int i = 0; i < RS_DEPTH; i++) begin
            cells_q[i] <= '0;
         end
      end else if (flush) begin
         valid_q       <= '0;
         issue_valid_q <= 1'b0;
         wr_err_q      <= 1'b0;
      end else begin
         for (int i = 0; i < RS_DEPTH; i++) begin
            cells_q[i] <= wake(cells_q[i], cdb_valid, cdb_tag, cdb_data);
         end
         if (load) begin
            if (cand_found) begin
               issue_valid_q     <= 1'b1;
               issue_cell_q      <= cells_q[cand_idx];
               valid_q[cand_idx] <= 1'b0;
            end else begin
               issue_valid_q <= 1'b0;
            end
         end
         wr_err_q <= wr_en && valid_q[wr_addr];
         // An empty target can never be the issuing slot, so no conflict.
         if (wr_en && !valid_q[wr_addr]) begin
            valid_q[wr_addr] <= 1'b1;
            cells_q[wr_addr] <= wake(wr_data, cdb_valid, cdb_tag, cdb_data);
         end
      end
   end

endmodule

// File: tb/tb_res_st_issue.sv
// Directed bench for res_st_issue with an issue-order scoreboard.
// Expected issued cells are queued at stimulus time and checked on handshake.
module tb_res_st_issue;
   import res_st_pkg::*;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             wr_en = 1'b0;
   res_st_addr_t     wr_addr = '0;
   res_st_cell_t     wr_data = '0;
   res_st_addr_t     free_addr;
   logic             full;
   logic [CNT_W-1:0] count;
   logic             cdb_valid = 1'b0;
   tag_t             cdb_tag = '0;
   data_t            cdb_data = '0;
   logic             issue_valid;
   logic             issue_ready = 1'b0;
   res_st_cell_t     issue_cell;
   logic             flush = 1'b0;
   logic             wr_err;

   int n_tests = 0;
   int n_fail  = 0;
   res_st_cell_t sb[$];

   res_st_issue dut (
      .clk(clk), .rst(rst),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .free_addr(free_addr), .full(full), .count(count),
      .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
      .issue_valid(issue_valid), .issue_ready(issue_ready),
      .issue_cell(issue_cell), .flush(flush), .wr_err(wr_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] obs,
                      input logic [127:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic res_st_cell_t mk(input int u, input int rd,
                                       input int t1, input bit r1, input int v1,
                                       input int t2, input bit r2, input int v2);
      res_st_cell_t c;
      c.uop     = UOP_WIDTH'(u);
      c.rd_tag  = TAG_WIDTH'(rd);
      c.rs1_tag = TAG_WIDTH'(t1);
      c.rs1_rdy = r1;
      c.rs1_val = DATA_WIDTH'(v1);
      c.rs2_tag = TAG_WIDTH'(t2);
      c.rs2_rdy = r2;
      c.rs2_val = DATA_WIDTH'(v2);
      return c;
   endfunction

   task automatic wr(input int a, input res_st_cell_t c);
      wr_en   = 1'b1;
      wr_addr = RS_AW'(a);
      wr_data = c;
      step();
      wr_en   = 1'b0;
   endtask

   task automatic bcast(input int t, input int d);
      cdb_valid = 1'b1;
      cdb_tag   = TAG_WIDTH'(t);
      cdb_data  = DATA_WIDTH'(d);
      step();
      cdb_valid = 1'b0;
   endtask

   // Handshake seen mid-cycle completes on the next rising edge.
   always @(negedge clk) begin
      if (rst && issue_valid && issue_ready) begin
         if (sb.size() == 0) begin
            chk("sb_unexpected_issue", 1'b1, 1'b0);
         end else begin
            chk("sb_issue_cell", issue_cell, sb.pop_front());
         end
      end
   end

   initial begin
      res_st_cell_t c, e, o3;

      #3;
      chk("rst_issue_valid", issue_valid, 1'b0);
      chk("rst_issue_cell", issue_cell, '0);
      chk("rst_full", full, 1'b0);
      chk("rst_free_addr", free_addr, '0);
      chk("rst_count", count, '0);
      chk("rst_wr_err", wr_err, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      step();

      issue_ready = 1'b1;
      c = mk(1, 1, 0, 1, 5, 0, 1, 10);
      sb.push_back(c);
      wr(0, c);
      chk("t1_not_yet", issue_valid, 1'b0);
      chk("t1_count_wr", count, 1);
      step();
      chk("t1_issue_valid", issue_valid, 1'b1);
      chk("t1_rs1_val", issue_cell.rs1_val, 5);
      chk("t1_rs2_val", issue_cell.rs2_val, 10);
      chk("t1_count", count, 0);
      chk("t1_free_addr", free_addr, 0);
      step();
      chk("t1_drain", issue_valid, 1'b0);

      c = mk(2, 2, 7, 0, 0, 0, 1, 3);
      wr(1, c);
      chk("t2_free_addr", free_addr, 0);
      step();
      step();
      bcast(6, 'h66);
      chk("t2_tag6_edge", issue_valid, 1'b0);
      step();
      chk("t2_tag6_none", issue_valid, 1'b0);
      chk("t2_count", count, 1);
      e = c;
      e.rs1_rdy = 1'b1;
      e.rs1_val = 'h55;
      sb.push_back(e);
      bcast(7, 'h55);
      chk("t2_wake_edge", issue_valid, 1'b0);
      step();
      chk("t2_issue_valid", issue_valid, 1'b1);
      chk("t2_rs1_val", issue_cell.rs1_val, 'h55);
      step();
      chk("t2_count_end", count, 0);

      issue_ready = 1'b0;
      for (int i = 0; i < RS_DEPTH; i++) begin
         chk("t3_free_addr_fill", free_addr, i);
         wr(i, mk('h30 + i, i, 20 + i, 0, 0, 40 + i, 0, 0));
      end
      o3 = mk('h33, 3, 23, 0, 0, 43, 0, 0);
      chk("t3_full", full, 1'b1);
      chk("t3_count", count, 8);
      chk("t3_free_addr", free_addr, 0);
      wr(3, mk('hff, 9, 0, 1, 1, 0, 1, 2));
      chk("t3_wr_err_pulse", wr_err, 1'b1);
      chk("t3_count_keep", count, 8);
      step();
      chk("t3_wr_err_fall", wr_err, 1'b0);
      e = o3;
      e.rs1_rdy = 1'b1;
      e.rs1_val = 'hA3;
      e.rs2_rdy = 1'b1;
      e.rs2_val = 'hB3;
      sb.push_back(e);
      issue_ready = 1'b1;
      bcast(23, 'hA3);
      bcast(43, 'hB3);
      chk("t3_wake_edge", issue_valid, 1'b0);
      step();
      chk("t3_issue_valid", issue_valid, 1'b1);
      chk("t3_count_after", count, 7);
      chk("t3_free_after", free_addr, 3);
      chk("t3_full_after", full, 1'b0);
      step();
      issue_ready = 1'b0;
      flush = 1'b1;
      step();
      flush = 1'b0;
      chk("t3_flush_count", count, 0);

      c = mk('h40, 1, 0, 1, 'h100, 0, 1, 'h200);
      sb.push_back(c);
      wr(0, c);
      chk("t4_count0", count, 1);
      e = mk('h41, 2, 0, 1, 'h101, 0, 1, 'h201);
      sb.push_back(e);
      wr(1, e);
      chk("t4_wr_issue_count", count, 1);
      chk("t4_issue_valid", issue_valid, 1'b1);
      o3 = mk('h42, 3, 0, 1, 'h102, 0, 1, 'h202);
      sb.push_back(o3);
      wr(2, o3);
      chk("t4_count2", count, 2);
      chk("t4_hold_a", issue_cell, c);
      step();
      chk("t4_hold_b", issue_cell, c);
      issue_ready = 1'b1;
      step();
      chk("t4_order1", issue_cell, e);
      step();
      chk("t4_order2", issue_cell, o3);
      step();
      chk("t4_drain", issue_valid, 1'b0);

      c = mk('h50, 5, 0, 1, 'h11, 9, 0, 0);
      e = c;
      e.rs2_rdy = 1'b1;
      e.rs2_val = 'h1234;
      sb.push_back(e);
      cdb_valid = 1'b1;
      cdb_tag   = TAG_WIDTH'(9);
      cdb_data  = 'h1234;
      wr(0, c);
      cdb_valid = 1'b0;
      chk("t5_not_yet", issue_valid, 1'b0);
      step();
      chk("t5_issue_valid", issue_valid, 1'b1);
      chk("t5_rs2_val", issue_cell.rs2_val, 'h1234);
      step();
      c = mk('h51, 6, 12, 0, 0, 12, 0, 0);
      wr(2, c);
      e = c;
      e.rs1_rdy = 1'b1;
      e.rs1_val = 'hC0C0;
      e.rs2_rdy = 1'b1;
      e.rs2_val = 'hC0C0;
      sb.push_back(e);
      step();
      bcast(12, 'hC0C0);
      step();
      chk("t5_dual_issue", issue_valid, 1'b1);
      step();
      chk("t5_drain", issue_valid, 1'b0);

      issue_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         wr(i, mk('h60 + i, i, 0, 1, i, 0, 1, i));
      end
      chk("t6_count", count, 4);
      chk("t6_issue_valid", issue_valid, 1'b1);
      flush   = 1'b1;
      wr_en   = 1'b1;
      wr_addr = RS_AW'(1);
      wr_data = mk('h6f, 1, 0, 1, 0, 0, 1, 0);
      step();
      flush = 1'b0;
      wr_en = 1'b0;
      chk("t6_flush_count", count, 0);
      chk("t6_flush_issue", issue_valid, 1'b0);
      chk("t6_flush_full", full, 1'b0);
      chk("t6_flush_wr_err", wr_err, 1'b0);
      step();
      chk("t6_post_count", count, 0);

      for (int i = 0; i < 3; i++) begin
         wr(i, mk('h70 + i, i, 0, 1, i, 0, 1, i));
      end
      wr(1, mk('h7f, 1, 0, 1, 0, 0, 1, 0));
      chk("t7_wr_err", wr_err, 1'b1);
      chk("t7_issue_valid", issue_valid, 1'b1);
      #2;
      rst = 1'b0;
      #1;
      chk("t7_rst_issue_valid", issue_valid, 1'b0);
      chk("t7_rst_issue_cell", issue_cell, '0);
      chk("t7_rst_count", count, 0);
      chk("t7_rst_full", full, 1'b0);
      chk("t7_rst_free_addr", free_addr, 0);
      chk("t7_rst_wr_err", wr_err, 1'b0);
      step();
      rst = 1'b1;
      step();
      chk("t7_post_issue", issue_valid, 1'b0);
      chk("t7_post_count", count, 0);

      chk("sb_empty", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
